alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. Adds shift operations and an optional iterative multiplier, registers the result and the five status flags (C, L, F, Z, N), and uses valid/ready on both sides so the control FSM can stall on multi-cycle operations. It sits between the register file read ports and the write-back/flag register in the CPU datapath.

## Interface
Parameters:
- `DATA_WIDTH`, default 16. Operand and result width; must be ≥ 4.
- `SHAMT_W`, default `$clog2(DATA_WIDTH)`. Width of the shift amount taken from `b`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands and opcode are valid.
- `in_ready`  out  1  block can accept an operation this cycle.
- `a`  in  DATA_WIDTH  operand A.
- `b`  in  DATA_WIDTH  operand B; shift amount is `b[SHAMT_W-1:0]`.
- `op`  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SAR, 8 SHR, 9 MUL; 10–15 reserved.
- `out_valid`  out  1  `result` and flags are valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `result`  out  DATA_WIDTH  registered result.
- `C`, `L`, `F`, `Z`, `N`  out  1 each  registered flags.

## Operation
- FSM states:
  - IDLE: `in_ready` = 1.
  - BUSY: multiply in progress; `in_ready` = 0.
  - DONE: `out_valid` = 1; `in_ready` = `out_ready`.
- Accept occurs when `in_valid & in_ready`. Operands and opcode are captured on that edge.
- Single-cycle ops go to DONE. MUL goes to BUSY.
- Flag rules:
  - ADD: `{C,result} = a+b`. F = signed overflow. N = `result[MSB] ^ F`, the true sign of the sum.
  - SUB: `{C,result} = a-b`. C = borrow. F = signed overflow. N = `result[MSB] ^ F`.
  - AND/OR/XOR/NOT: C = F = N = 0.
  - SHL: C = last bit shifted out (0 when amount is 0).
  - SAR: arithmetic right shift. C = last bit shifted out.
  - SHR: logical right shift. C = last bit shifted out. F = N = 0 for all shifts.
  - MUL: result = low DATA_WIDTH bits of the unsigned product. C = 1 if any high product bit is nonzero. F = N = 0.
  - All ops: Z = (result == 0). L = unsigned(a) < unsigned(b), computed on the captured operands.
- Reserved opcodes: result = 0, Z = 1, L per rule, all other flags 0; single-cycle.
- In DONE with `out_ready` = 0, `result` and flags hold stable.
- In DONE with `out_ready` = 1:
  - If `in_valid` = 1, the new op is accepted in the same cycle. A single-cycle op stays in DONE with the new result; MUL goes to BUSY.
  - Otherwise the FSM returns to IDLE.

## Timing
- Reset state: IDLE. `out_valid` = 0, `result` = 0, all flags = 0.
- Single-cycle op latency: `out_valid` is high on the edge after accept (1 cycle).
- MUL latency: BUSY lasts DATA_WIDTH cycles, one partial product per cycle. `out_valid` rises DATA_WIDTH+1 edges after accept.
- Throughput: back-to-back single-cycle ops run at 1 op/cycle when `out_ready` is held high.
- Reset asserted mid-multiply aborts the operation. No `out_valid` pulse is produced for it.
- Operands and opcode are don't-care when not accepted. Changing `a`, `b` or `op` during BUSY has no effect.

## Configuration
- `ALU_MUL_EN` defined:
  - The iterative multiplier is instantiated and MUL behaves as above.
- `ALU_MUL_EN` undefined:
  - Opcode 9 is treated as reserved: single-cycle, result 0, Z = 1.
  - The BUSY state is never entered and no multiplier logic is synthesised.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams (`OP_ADD` … `OP_MUL`);
  - the FSM state typedef/encoding;
  - the flag vector ordering `{C,L,F,Z,N}`.
- Sub-module `alu_mul_iter` is a shift-add unsigned multiplier. Its interface is `start`/`done`, DATA_WIDTH-cycle latency, and a 2×DATA_WIDTH product.
- It is instantiated only under `ALU_MUL_EN`. The top level holds the FSM, the combinational single-cycle ops and the output registers.

## Test plan
All cases use DATA_WIDTH = 16.
1. ADD a=0x7FFF, b=0x0001 → result 0x8000, F=1, N=0, C=0, Z=0, L=0, `out_valid` one cycle after accept.
2. SUB a=0x0003, b=0x0005 → result 0xFFFE, C=1, L=1, N=1, F=0. Then SUB a=0x8000, b=0x0001 → 0x7FFF, F=1, N=1.
3. SAR a=0x8004, b=2 → 0xE001, C=0. Then SHL a=0xC000, b=1 → 0x8000, C=1. Then SHR a=0x0001, b=1 → 0x0000, C=1, Z=1.
4. MUL (`ALU_MUL_EN`) a=0x0100, b=0x0100 → result 0x0000, C=1, Z=1, `out_valid` 17 edges after accept, `in_ready` low throughout BUSY. Without the macro: MUL completes in 1 cycle with result 0, Z=1.
5. Backpressure: hold `out_ready` low for 3 cycles after an ADD → result and flags stable, `in_ready` low. Raise `out_ready` with `in_valid` high → next op accepted that edge.
6. Reset mid-multiply, at the 5th cycle of BUSY → next cycle IDLE, `out_valid`=0, `result`=0, flags 0. A subsequent ADD 1+1 → 0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag layout for the handshaked ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL = 4'd6;
  localparam logic [OP_W-1:0] OP_SAR = 4'd7;
  localparam logic [OP_W-1:0] OP_SHR = 4'd8;
  localparam logic [OP_W-1:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Packed so the struct reads out directly as {C,L,F,Z,N}.
  typedef struct packed {
    logic c;
    logic l;
    logic f;
    logic z;
    logic n;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier: one partial product per cycle, done pulses
// DATA_WIDTH cycles after start.
module alu_mul_iter #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(W) + 1;

  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mplier;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= '0;
        mcand   <= {{W{1'b0}}, a};
        mplier  <= b;
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          product <= product + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags. Define ALU_MUL_EN to build the
// iterative multiplier; otherwise opcode 9 behaves as a reserved opcode.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OP_W-1:0]       op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  C,
  output logic                  L,
  output logic                  F,
  output logic                  Z,
  output logic                  N
);

  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned MSB = W - 1;

  state_t         state;
  flags_t         flags;
  flags_t         alu_flags;
  logic [W-1:0]   alu_res;
  logic           accept;
  logic           start_mul;

  logic [SHAMT_W-1:0] shamt;
  logic [W:0]         sum;
  logic [W:0]         diff;
  logic [W:0]         shl_w;
  logic [W:0]         shr_w;
  logic [W:0]         sar_w;
  logic               add_ovf;
  logic               sub_ovf;

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign {C, L, F, Z, N} = flags;

  // Shifts carry one guard bit so the last bit shifted out lands in it.
  assign shamt   = b[SHAMT_W-1:0];
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign shl_w   = {1'b0, a} << shamt;
  assign shr_w   = {a, 1'b0} >> shamt;
  assign sar_w   = $signed({a, 1'b0}) >>> shamt;
  assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

  // Single-cycle datapath; reserved opcodes fall through to zero.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (op)
      OP_ADD: begin
        alu_res     = sum[W-1:0];
        alu_flags.c = sum[W];
        alu_flags.f = add_ovf;
        alu_flags.n = sum[MSB] ^ add_ovf;
      end
      OP_SUB: begin
        alu_res     = diff[W-1:0];
        alu_flags.c = diff[W];
        alu_flags.f = sub_ovf;
        alu_flags.n = diff[MSB] ^ sub_ovf;
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res     = shl_w[W-1:0];
        alu_flags.c = shl_w[W];
      end
      OP_SAR: begin
        alu_res     = sar_w[W:1];
        alu_flags.c = sar_w[0];
      end
      OP_SHR: begin
        alu_res     = shr_w[W:1];
        alu_flags.c = shr_w[0];
      end
      default: alu_res = '0;
    endcase
    alu_flags.z = (alu_res == '0);
    alu_flags.l = (a < b);
  end

`ifdef ALU_MUL_EN
  logic           mul_done;
  logic [2*W-1:0] mul_prod;
  logic           mul_l;
  flags_t         mul_flags;

  assign start_mul = accept && (op == OP_MUL);

  alu_mul_iter #(
    .DATA_WIDTH(W)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (start_mul),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_prod)
  );

  // L must reflect the operands captured at accept, not whatever is on a/b later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_l <= 1'b0;
    end else if (start_mul) begin
      mul_l <= (a < b);
    end
  end

  always_comb begin
    mul_flags   = '0;
    mul_flags.c = |mul_prod[2*W-1:W];
    mul_flags.l = mul_l;
    mul_flags.z = (mul_prod[W-1:0] == '0);
  end
`else
  assign start_mul = 1'b0;
`endif

  // Control FSM and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_mul) begin
            state     <= ST_BUSY;
            out_valid <= 1'b0;
          end else if (accept) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= alu_res;
            flags     <= alu_flags;
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        ST_BUSY: begin
          if (mul_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= mul_prod[W-1:0];
            flags     <= mul_flags;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
